// File: rtl/mantissa_multiplier_seq.sv
// Iterative mantissa multiplier: shift-add over BITS_PER_CYCLE multiplier bits
// per clock, then normalise and round (RNE or RTZ) in one cycle. Operands are
// normalised fractions with the hidden 1 implied; specials are handled upstream.
module mantissa_multiplier_seq #(
   parameter int BIT_WIDTH      = 23,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in0,
   input  logic [BIT_WIDTH-1:0] in1,
   input  logic                 round_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out,
   output logic                 carry,
   output logic                 inexact
);
   // state   | meaning
   // S_IDLE  | waiting for operands, in_ready high
   // S_MUL   | shift-add iterations, N cycles
   // S_ROUND | normalise and round the exact product
   // S_DONE  | result presented until out_ready

   localparam int W  = BIT_WIDTH;
   localparam int K  = BITS_PER_CYCLE;
   localparam int N  = (W + 1) / K;
   localparam int PW = 2 * W + 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (W < 3 || K < 1 || ((W + 1) % K) != 0) begin : g_bad_params
         $error("mantissa_multiplier_seq: BIT_WIDTH must be >= 3 and BITS_PER_CYCLE must divide BIT_WIDTH+1");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ROUND, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [W:0]      mcand_q, mcand_d;
   logic [W:0]      mplier_q, mplier_d;
   logic            mode_q, mode_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    out_q, out_d;
   logic            carry_q, carry_d;
   logic            inexact_q, inexact_d;
   logic            out_valid_q, out_valid_d;

   logic [W+K:0]    partial;
   logic [W+K:0]    sum_hi;
   logic [PW+K-1:0] acc_wide;
   logic [PW-1:0]   acc_step;

   logic            rnd_c, rnd_g, rnd_r, rnd_s, rnd_inc;
   logic [W-1:0]    rnd_m;
   logic [W:0]      rnd_m_inc;
   logic [W-1:0]    rnd_out;
   logic            rnd_carry;

   // Reset wins over acceptance, so in_ready is held low while rst is asserted.
   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign carry     = carry_q;
   assign inexact   = inexact_q;

   // One shift-add step: add slice*multiplicand into the upper half, shift right by K.
   always_comb begin
      partial  = (W+K+1)'(mplier_q[K-1:0]) * (W+K+1)'(mcand_q);
      sum_hi   = {{K{1'b0}}, acc_q[PW-1:W+1]} + partial;
      acc_wide = {sum_hi, acc_q[W:0]};
      acc_step = acc_wide[PW+K-1:K];
   end

   // Normalise the exact product, derive guard/round/sticky, apply the rounding mode.
   always_comb begin
      rnd_c     = acc_q[PW-1];
      rnd_m     = rnd_c ? acc_q[2*W:W+1] : acc_q[2*W-1:W];
      rnd_g     = rnd_c ? acc_q[W]       : acc_q[W-1];
      rnd_r     = rnd_c ? acc_q[W-1]     : acc_q[W-2];
      rnd_s     = rnd_c ? (|acc_q[W-2:0]) : (|acc_q[W-3:0]);
      rnd_inc   = !mode_q && rnd_g && (rnd_r || rnd_s || rnd_m[0]);
      rnd_m_inc = {1'b0, rnd_m} + (W+1)'(rnd_inc);
      if (rnd_m_inc[W]) begin
         rnd_out   = '0;
         rnd_carry = 1'b1;
      end else begin
         rnd_out   = rnd_m_inc[W-1:0];
         rnd_carry = rnd_c;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      carry_d     = carry_q;
      inexact_d   = inexact_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               mcand_d  = {1'b1, in0};
               mplier_d = {1'b1, in1};
               mode_d   = round_mode;
               acc_d    = '0;
               cnt_d    = CW'(N - 1);
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> K;
            if (cnt_q == '0) state_d = S_ROUND;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_ROUND: begin
            out_d       = rnd_out;
            carry_d     = rnd_carry;
            inexact_d   = rnd_g || rnd_r || rnd_s;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register bank with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         mode_q      <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         carry_q     <= 1'b0;
         inexact_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         carry_q     <= carry_d;
         inexact_q   <= inexact_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// Directed bench for mantissa_multiplier_seq: W=23/K=1, W=23/K=4 and W=3/K=1 instances.
module tb_mantissa_multiplier_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // instance a: W=23, K=1
   logic        iv_a, ir_a, mode_a, ov_a, ordy_a, c_a, x_a;
   logic [22:0] i0_a, i1_a, o_a;
   // instance b: W=23, K=4
   logic        iv_b, ir_b, mode_b, ov_b, ordy_b, c_b, x_b;
   logic [22:0] i0_b, i1_b, o_b;
   // instance c: W=3, K=1
   logic        iv_c, ir_c, mode_c, ov_c, ordy_c, c_c, x_c;
   logic [2:0]  i0_c, i1_c, o_c;

   mantissa_multiplier_seq #(.BIT_WIDTH(23), .BITS_PER_CYCLE(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .in0(i0_a), .in1(i1_a),
      .round_mode(mode_a), .out_valid(ov_a), .out_ready(ordy_a), .out(o_a),
      .carry(c_a), .inexact(x_a));

   mantissa_multiplier_seq #(.BIT_WIDTH(23), .BITS_PER_CYCLE(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .in0(i0_b), .in1(i1_b),
      .round_mode(mode_b), .out_valid(ov_b), .out_ready(ordy_b), .out(o_b),
      .carry(c_b), .inexact(x_b));

   mantissa_multiplier_seq #(.BIT_WIDTH(3), .BITS_PER_CYCLE(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .in0(i0_c), .in1(i1_c),
      .round_mode(mode_c), .out_valid(ov_c), .out_ready(ordy_c), .out(o_c),
      .carry(c_c), .inexact(x_c));

   // Accept one operation on instance a and count cycles until out_valid; operands are
   // scrambled while the operation runs since they must be ignored outside IDLE.
   task automatic run_a(input logic [22:0] a, input logic [22:0] b, input logic m,
                        output int lat, output bit rdy_seen);
      i0_a = a; i1_a = b; mode_a = m; iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0; lat = 0; rdy_seen = 1'b0;
      while (!ov_a && lat < 200) begin
         i0_a = 23'($urandom); i1_a = 23'($urandom); mode_a = 1'($urandom);
         if (ir_a) rdy_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_a();
      ordy_a = 1'b1;
      @(posedge clk); #1;
      ordy_a = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (ir_a !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_during got %b want 0", ir_a); end
      rst = 1'b0;
      #1;
      n_cmp++; if (ir_a !== 1'b1 || ir_b !== 1'b1 || ir_c !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_after got %b%b%b want 111", ir_a, ir_b, ir_c); end
      n_cmp++; if (ov_a !== 1'b0 || o_a !== 23'h0 || c_a !== 1'b0 || x_a !== 1'b0) begin n_err++; $display("FAIL reset_outputs got v=%b o=%h c=%b x=%b want 0", ov_a, o_a, c_a, x_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_rounding();
      logic [22:0] v_in0 [6];
      logic [22:0] v_in1 [6];
      logic        v_mode [6];
      logic [22:0] v_out [6];
      logic        v_c [6];
      logic        v_x [6];
      int lat;
      bit rs;
      v_in0 = '{23'h000000, 23'h400000, 23'h7FFFFF, 23'h000001, 23'h000001, 23'h000003};
      v_in1 = '{23'h000000, 23'h400000, 23'h7FFFFF, 23'h400000, 23'h400000, 23'h400000};
      v_mode = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      v_out = '{23'h000000, 23'h100000, 23'h7FFFFE, 23'h400002, 23'h400001, 23'h400004};
      v_c   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      v_x   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         run_a(v_in0[i], v_in1[i], v_mode[i], lat, rs);
         n_cmp++; if (lat != 25) begin n_err++; $display("FAIL round[%0d] latency got %0d want 25", i, lat); end
         n_cmp++; if (rs) begin n_err++; $display("FAIL round[%0d] in_ready_busy got 1 want 0", i); end
         n_cmp++; if (o_a !== v_out[i]) begin n_err++; $display("FAIL round[%0d] out got %h want %h", i, o_a, v_out[i]); end
         n_cmp++; if (c_a !== v_c[i]) begin n_err++; $display("FAIL round[%0d] carry got %b want %b", i, c_a, v_c[i]); end
         n_cmp++; if (x_a !== v_x[i]) begin n_err++; $display("FAIL round[%0d] inexact got %b want %b", i, x_a, v_x[i]); end
         release_a();
         n_cmp++; if (ov_a !== 1'b0 || ir_a !== 1'b1) begin n_err++; $display("FAIL round[%0d] release got v=%b r=%b want v=0 r=1", i, ov_a, ir_a); end
         n_cmp++; if (o_a !== v_out[i] || c_a !== v_c[i] || x_a !== v_x[i]) begin n_err++; $display("FAIL round[%0d] hold_after got o=%h c=%b x=%b want o=%h c=%b x=%b", i, o_a, c_a, x_a, v_out[i], v_c[i], v_x[i]); end
      end
   endtask

   task automatic test_round_overflow();
      int lat;
      i0_c = 3'b001; i1_c = 3'b110; mode_c = 1'b0; iv_c = 1'b1;
      @(posedge clk); #1;
      iv_c = 1'b0; lat = 0;
      while (!ov_c && lat < 50) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (lat != 5) begin n_err++; $display("FAIL ovf latency got %0d want 5", lat); end
      n_cmp++; if (o_c !== 3'b000 || c_c !== 1'b1 || x_c !== 1'b1) begin n_err++; $display("FAIL ovf result got o=%b c=%b x=%b want o=000 c=1 x=1", o_c, c_c, x_c); end
      ordy_c = 1'b1; @(posedge clk); #1; ordy_c = 1'b0;
      n_cmp++; if (ov_c !== 1'b0 || ir_c !== 1'b1) begin n_err++; $display("FAIL ovf release got v=%b r=%b want v=0 r=1", ov_c, ir_c); end
   endtask

   task automatic test_backpressure_k4();
      int lat;
      i0_b = 23'h400000; i1_b = 23'h400000; mode_b = 1'b0; iv_b = 1'b1;
      @(posedge clk); #1;
      iv_b = 1'b0; lat = 0;
      while (!ov_b && lat < 50) begin
         i0_b = 23'($urandom); i1_b = 23'($urandom);
         @(posedge clk); #1; lat++;
      end
      n_cmp++; if (lat != 7) begin n_err++; $display("FAIL k4 latency got %0d want 7", lat); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (ov_b !== 1'b1 || o_b !== 23'h100000 || c_b !== 1'b1 || x_b !== 1'b0 || ir_b !== 1'b0) begin
            n_err++; $display("FAIL k4 hold[%0d] got v=%b o=%h c=%b x=%b r=%b want v=1 o=100000 c=1 x=0 r=0", i, ov_b, o_b, c_b, x_b, ir_b);
         end
         iv_b = 1'b1;
         @(posedge clk); #1;
         iv_b = 1'b0;
      end
      ordy_b = 1'b1; @(posedge clk); #1; ordy_b = 1'b0;
      n_cmp++; if (ov_b !== 1'b0 || ir_b !== 1'b1) begin n_err++; $display("FAIL k4 release got v=%b r=%b want v=0 r=1", ov_b, ir_b); end
      n_cmp++; if (o_b !== 23'h100000 || c_b !== 1'b1) begin n_err++; $display("FAIL k4 hold_after got o=%h c=%b want o=100000 c=1", o_b, c_b); end
   endtask

   task automatic test_abort();
      int lat;
      bit rs;
      bit spurious;
      i0_a = 23'h400000; i1_a = 23'h400000; mode_a = 1'b0; iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_cmp++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin n_err++; $display("FAIL abort handshake got r=%b v=%b want r=1 v=0", ir_a, ov_a); end
      n_cmp++; if (o_a !== 23'h0 || c_a !== 1'b0 || x_a !== 1'b0) begin n_err++; $display("FAIL abort outputs got o=%h c=%b x=%b want 0", o_a, c_a, x_a); end
      spurious = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (ov_a) spurious = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++; if (spurious) begin n_err++; $display("FAIL abort partial_result got out_valid=1 want 0"); end
      run_a(23'h400000, 23'h400000, 1'b0, lat, rs);
      n_cmp++; if (lat != 25) begin n_err++; $display("FAIL abort rerun latency got %0d want 25", lat); end
      n_cmp++; if (o_a !== 23'h100000 || c_a !== 1'b1 || x_a !== 1'b0) begin n_err++; $display("FAIL abort rerun got o=%h c=%b x=%b want o=100000 c=1 x=0", o_a, c_a, x_a); end
      release_a();
   endtask

   initial begin
      iv_a = 1'b0; mode_a = 1'b0; ordy_a = 1'b0; i0_a = '0; i1_a = '0;
      iv_b = 1'b0; mode_b = 1'b0; ordy_b = 1'b0; i0_b = '0; i1_b = '0;
      iv_c = 1'b0; mode_c = 1'b0; ordy_c = 1'b0; i0_c = '0; i1_c = '0;
      test_reset();
      test_rounding();
      test_round_overflow();
      test_backpressure_k4();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end
endmodule
